// File: rtl/avalon_block_reader.sv
// Avalon-MM block reader: fetches word_count 32-bit words from base_addr with
// one read in flight at a time, and streams them out through a small FIFO.
module avalon_block_reader #(
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic [31:0]      avl_address,
  output logic             avl_read,
  output logic             avl_write,
  output logic [3:0]       avl_byteenable,
  output logic [31:0]      avl_writedata,
  input  logic             avl_waitrequest,
  input  logic [31:0]      avl_readdata,
  input  logic             avl_readdatavalid,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       fsm_state
);

  // Handshakes: an Avalon read is accepted on an edge with avl_read=1 and
  // avl_waitrequest=0; a stream word moves on an edge with out_valid=1 and
  // out_ready=1. Neither valid waits on its ready.

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;
  localparam logic [1:0] FLUSH     = 2'd3;

  logic [1:0]       state;
  logic [31:0]      addr;
  logic [LEN_W-1:0] remaining;
  logic             busy_q;
  logic             done_q;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic [AW:0]      level_next;
  logic             push;
  logic             pop;
  logic             accept;

  // Only pops can happen while in ISSUE, so once avl_read rises it stays up
  // until accepted, keeping the request stable under waitrequest.
  assign avl_read       = (state == ISSUE) && (level < FULL_LEVEL);
  assign avl_address    = addr;
  assign avl_write      = 1'b0;
  assign avl_byteenable = 4'hF;
  assign avl_writedata  = 32'd0;
  assign accept         = avl_read && !avl_waitrequest;

  assign push      = (state == WAIT_DATA) && avl_readdatavalid;
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : 32'd0;

  assign busy      = busy_q;
  assign done      = done_q;
  assign fsm_state = state;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + (AW+1)'(1);
      2'b01:   level_next = level - (AW+1)'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avl_readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= 32'd0;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (done_q) busy_q <= 1'b0;
      case (state)
        IDLE: begin
          // busy_q is still high during the done cycle, which masks a start there.
          if (start && !busy_q) begin
            busy_q <= 1'b1;
            if (word_count == '0) begin
              done_q <= 1'b1;
            end else begin
              addr      <= base_addr & ~32'h3;
              remaining <= word_count;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (accept) begin
            addr      <= addr + 32'd4;
            remaining <= remaining - LEN_W'(1);
            state     <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (avl_readdatavalid) begin
            state <= (remaining != '0) ? ISSUE : FLUSH;
          end
        end
        default: begin
          if (level_next == '0) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_block_reader.sv
// Bench for avalon_block_reader: word-addressed memory agent, stream sink,
// expected-data/address queues and a summary line.
module tb_avalon_block_reader;

  localparam int LEN_W      = 12;
  localparam int FIFO_DEPTH = 8;
  localparam int MEM_WORDS  = 2048;

  logic             clk;
  logic             reset;
  logic             start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] word_count;
  logic             busy;
  logic             done;
  logic [31:0]      avl_address;
  logic             avl_read;
  logic             avl_write;
  logic [3:0]       avl_byteenable;
  logic [31:0]      avl_writedata;
  logic             avl_waitrequest;
  logic [31:0]      avl_readdata;
  logic             avl_readdatavalid;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       fsm_state;

  avalon_block_reader #(.LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .avl_address       (avl_address),
    .avl_read          (avl_read),
    .avl_write         (avl_write),
    .avl_byteenable    (avl_byteenable),
    .avl_writedata     (avl_writedata),
    .avl_waitrequest   (avl_waitrequest),
    .avl_readdata      (avl_readdata),
    .avl_readdatavalid (avl_readdatavalid),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .fsm_state         (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int reads_accepted = 0;
  int read_cycles    = 0;
  int stall_cycles   = 0;
  int done_seen      = 0;
  int done_expected  = 0;
  int stall_left     = 0;
  int stall_target   = 0;
  int ready_mode     = 1;
  logic stray_rdv    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + ((a >> 2) & 32'(MEM_WORDS - 1));
  endfunction

  // ---------------- Avalon agent ----------------
  initial begin : agent
    logic will_accept;
    logic [31:0] acc_addr;
    avl_waitrequest   = 1'b0;
    avl_readdatavalid = 1'b0;
    avl_readdata      = 32'd0;
    forever begin
      @(negedge clk);
      will_accept = (avl_read === 1'b1) && !avl_waitrequest;
      acc_addr    = avl_address;
      if (avl_read === 1'b1) begin
        read_cycles++;
        if (exp_addr_q.size() == 0) check("spurious_read", 32'd1, 32'd0);
        else check("avl_address", avl_address, exp_addr_q[0]);
      end
      if (avl_waitrequest) begin
        stall_cycles++;
        check("stall_read_held", {31'd0, avl_read}, 32'd1);
      end
      if (will_accept && exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
      @(posedge clk);
      #1;
      avl_readdatavalid = will_accept || stray_rdv;
      avl_readdata      = will_accept ? mem_word(acc_addr) : $urandom;
      stray_rdv         = 1'b0;
      if (will_accept) reads_accepted++;
      if (avl_read === 1'b1 && stall_left > 0 && reads_accepted + 1 == stall_target) begin
        avl_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avl_waitrequest = 1'b0;
      end
    end
  end

  // ---------------- stream sink ----------------
  initial begin : sink
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- output monitor ----------------
  initial begin : monitor
    logic prev_hold;
    logic [31:0] prev_data;
    prev_hold = 1'b0;
    prev_data = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (prev_hold && out_valid) check("out_data_stable", out_data, prev_data);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_word", out_data, 32'hxxxx_xxxx);
          else check("out_data", out_data, exp_q.pop_front());
        end
        if (done === 1'b1) begin
          done_seen++;
          check("done_after_last_pop", 32'(exp_q.size()) | {31'd0, out_valid}, 32'd0);
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input logic [31:0] base, input int cnt);
    logic [31:0] a;
    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt[LEN_W-1:0];
    for (int i = 0; i < cnt; i++) begin
      a = (base & ~32'h3) + 32'(4 * i);
      exp_addr_q.push_back(a);
      exp_q.push_back(mem_word(a));
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    check({name, "_done"}, {31'd0, done}, 32'd1);
    done_expected++;
    @(negedge clk);
    check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int r0;
    int rc0;
    int s0;
    int d0;
    int n;
    int cnt;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = 32'd0;
    word_count = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_avl_read", {31'd0, avl_read}, 32'd0);
    check("rst_avl_address", avl_address, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("avl_write", {31'd0, avl_write}, 32'd0);
    check("avl_byteenable", {28'd0, avl_byteenable}, 32'hF);
    check("avl_writedata", avl_writedata, 32'd0);
    reset = 1'b0;

    // basic block of four words from 0x10
    r0 = reads_accepted;
    issue_start(32'h10, 4);
    wait_done(200, "basic");
    check("basic_reads", 32'(reads_accepted - r0), 32'd4);

    // sink stalled: FIFO fills, then reads stop
    ready_mode = 0;
    r0 = reads_accepted;
    issue_start(32'h100, 20);
    repeat (60) @(negedge clk);
    check("backpressure_reads", 32'(reads_accepted - r0), 32'd8);
    check("backpressure_no_read", {31'd0, avl_read}, 32'd0);
    check("backpressure_valid", {31'd0, out_valid}, 32'd1);
    ready_mode = 1;
    wait_done(400, "backpressure");
    check("backpressure_total_reads", 32'(reads_accepted - r0), 32'd20);

    // waitrequest held for 5 cycles on the second read
    r0 = reads_accepted;
    s0 = stall_cycles;
    stall_target = r0 + 2;
    stall_left   = 5;
    issue_start(32'h40, 4);
    wait_done(200, "stall");
    check("stall_cycles", 32'(stall_cycles - s0), 32'd5);
    check("stall_reads", 32'(reads_accepted - r0), 32'd4);

    // zero-length block, plus a start landing on its done cycle
    rc0 = read_cycles;
    issue_start(32'h200, 0);
    check("zero_done", {31'd0, done}, 32'd1);
    done_expected++;
    start      = 1'b1;
    base_addr  = 32'h300;
    word_count = LEN_W'(3);
    @(negedge clk);
    start = 1'b0;
    check("zero_done_one_cycle", {31'd0, done}, 32'd0);
    check("zero_busy_low", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("zero_no_reads", 32'(read_cycles - rc0), 32'd0);
    check("start_on_done_ignored", {31'd0, busy}, 32'd0);

    // reset while waiting for the third of ten words
    r0 = reads_accepted;
    d0 = done_seen;
    issue_start(32'h300, 10);
    n = 0;
    while (reads_accepted != r0 + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reset_reached_word3", 32'(reads_accepted - r0), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_avl_read", {31'd0, avl_read}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    stray_rdv = 1'b1;
    repeat (2) @(negedge clk);
    check("stray_rdv_ignored", {31'd0, out_valid}, 32'd0);
    check("abort_state_idle", {30'd0, fsm_state}, 32'd0);
    check("abort_no_done", 32'(done_seen - d0), 32'd0);
    issue_start(32'h500, 2);
    wait_done(100, "after_reset");

    // 32-bit address wrap
    issue_start(32'hFFFF_FFFC, 2);
    wait_done(100, "wrap");

    // randomized blocks with random sink readiness and occasional stalls
    ready_mode = 2;
    for (int b = 0; b < 8; b++) begin
      cnt = $urandom_range(1, 24);
      if ($urandom_range(0, 1) == 1) begin
        stall_target = reads_accepted + $urandom_range(1, cnt);
        stall_left   = $urandom_range(1, 4);
      end
      issue_start($urandom, cnt);
      wait_done(800, "random");
    end
    ready_mode = 1;

    repeat (5) @(negedge clk);
    check("final_done_count", 32'(done_seen), 32'(done_expected));
    check("final_addr_queue", 32'(exp_addr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
